// File: rtl/design07_arbiter.sv
// design07_arbiter: round-robin sharing of one start/result/check compute unit
// between two clients, each with a one-entry request buffer and a one-entry
// response buffer. The operation sequence is IDLE -> ISSUE -> WAIT -> IDLE.
module design07_arbiter #(
  parameter int W       = 11,
  parameter int TIMEOUT = 255
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en_req0,
  input  logic [W-1:0] i_req0_a,
  input  logic [W-1:0] i_req0_b,
  output logic         o_rdy_req0,
  input  logic         i_en_req1,
  input  logic [W-1:0] i_req1_a,
  input  logic [W-1:0] i_req1_b,
  output logic         o_rdy_req1,
  input  logic         i_en_resp0,
  output logic [W-1:0] o_resp0_result,
  output logic [W-1:0] o_resp0_check,
  output logic         o_rdy_resp0,
  input  logic         i_en_resp1,
  output logic [W-1:0] o_resp1_result,
  output logic [W-1:0] o_resp1_check,
  output logic         o_rdy_resp1,
  output logic [W-1:0] o_dut_start_a,
  output logic [W-1:0] o_dut_start_b,
  output logic         o_dut_en_start,
  input  logic         i_dut_rdy_start,
  input  logic [W-1:0] i_dut_result,
  input  logic [W-1:0] i_dut_check,
  input  logic         i_dut_rdy_result,
  input  logic         i_dut_rdy_check,
  output logic         o_dut_en_check,
  output logic         o_busy,
  output logic         o_owner,
  output logic         o_err_timeout
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_owner;
  logic              r_last_grant;
  logic              r_err_timeout;
  logic [7:0]        r_wait_cnt;

  logic [1:0]        w_en_req;
  logic [1:0]        w_en_resp;
  logic [1:0]        w_req_full;
  logic [1:0]        w_resp_full;
  logic [1:0][W-1:0] w_in_a;
  logic [1:0][W-1:0] w_in_b;
  logic [1:0][W-1:0] w_req_a;
  logic [1:0][W-1:0] w_req_b;
  logic [1:0][W-1:0] w_resp_result;
  logic [1:0][W-1:0] w_resp_check;
  logic              w_start_fire;
  logic              w_check_fire;
  logic              w_grant;

  assign w_en_req  = {i_en_req1, i_en_req0};
  assign w_en_resp = {i_en_resp1, i_en_resp0};
  assign w_in_a    = {i_req1_a, i_req0_a};
  assign w_in_b    = {i_req1_b, i_req0_b};

  // Handshakes depend only on state, registered owner and unit RDY inputs.
  assign w_start_fire = (r_state == S_ISSUE) && i_dut_rdy_start;
  assign w_check_fire = (r_state == S_WAIT) && i_dut_rdy_result && i_dut_rdy_check
                        && !w_resp_full[r_owner];

  // With both clients pending, the one not granted last time wins.
  assign w_grant = (&w_req_full) ? ~r_last_grant : w_req_full[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_client
      logic         r_req_full;
      logic [W-1:0] r_req_a;
      logic [W-1:0] r_req_b;
      logic         r_resp_full;
      logic [W-1:0] r_resp_result;
      logic [W-1:0] r_resp_check;
      logic         w_mine;

      assign w_mine = (r_owner == 1'(gi));

      // Request buffer: filled by the client, freed when its start fires.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_req_full <= 1'b0;
          r_req_a    <= '0;
          r_req_b    <= '0;
        end else if (w_en_req[gi]) begin
          r_req_full <= 1'b1;
          r_req_a    <= w_in_a[gi];
          r_req_b    <= w_in_b[gi];
        end else if (w_start_fire && w_mine) begin
          r_req_full <= 1'b0;
        end
      end

      // Response buffer: filled on completion, emptied by the client dequeue.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_resp_full   <= 1'b0;
          r_resp_result <= '0;
          r_resp_check  <= '0;
        end else if (w_check_fire && w_mine) begin
          r_resp_full   <= 1'b1;
          r_resp_result <= i_dut_result;
          r_resp_check  <= i_dut_check;
        end else if (w_en_resp[gi]) begin
          r_resp_full <= 1'b0;
        end
      end

      assign w_req_full[gi]    = r_req_full;
      assign w_req_a[gi]       = r_req_a;
      assign w_req_b[gi]       = r_req_b;
      assign w_resp_full[gi]   = r_resp_full;
      assign w_resp_result[gi] = r_resp_result;
      assign w_resp_check[gi]  = r_resp_check;
    end
  endgenerate

  // Operation sequencer with arbitration pointer, wait counter and sticky timeout.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_owner       <= 1'b0;
      r_last_grant  <= 1'b1;
      r_wait_cnt    <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_req_full) begin
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_start_fire) begin
            r_wait_cnt <= '0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_check_fire) begin
            r_state <= S_IDLE;
          end else begin
            if (r_wait_cnt != 8'hFF) r_wait_cnt <= r_wait_cnt + 8'd1;
            if (r_wait_cnt == TO_LIMIT) r_err_timeout <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rdy_req0     = ~w_req_full[0];
  assign o_rdy_req1     = ~w_req_full[1];
  assign o_rdy_resp0    = w_resp_full[0];
  assign o_rdy_resp1    = w_resp_full[1];
  assign o_resp0_result = w_resp_result[0];
  assign o_resp0_check  = w_resp_check[0];
  assign o_resp1_result = w_resp_result[1];
  assign o_resp1_check  = w_resp_check[1];
  assign o_dut_start_a  = (r_state == S_ISSUE) ? w_req_a[r_owner] : '0;
  assign o_dut_start_b  = (r_state == S_ISSUE) ? w_req_b[r_owner] : '0;
  assign o_dut_en_start = w_start_fire;
  assign o_dut_en_check = w_check_fire;
  assign o_busy         = (r_state != S_IDLE);
  assign o_owner        = r_owner;
  assign o_err_timeout  = r_err_timeout;

endmodule
